// File: rtl/push_router.sv
// Routes words from one upstream source to four destination FIFOs through a
// 2-entry in-order buffer, honouring per-destination full/almost-full flags.
module push_router #(
    parameter int DATA_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [3:0]            full,
    input  logic [3:0]            almost_full,
    output logic [3:0]            push,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            push_id,
    output logic [7:0]            push_total
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]            state_reg, state_next;
    logic                  rd_ptr_reg, wr_ptr_reg;
    logic [3:0]            push_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic [1:0]            push_id_reg;
    logic [7:0]            push_total_reg;

    logic                  accept;
    logic                  dispatch;
    logic [DATA_WIDTH-1:0] head;
    logic [1:0]            head_dest;

    // Registered-state only, so upstream never sees a path from full/almost_full.
    assign ready_out = ((state_reg == ST_EMPTY) || (state_reg == ST_ONE)) && !reset;
    assign accept    = valid_in && ready_out;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (accept && (int'(wr_ptr_reg) == gi)) begin
                    entry_reg <= data_in;
                end
            end
        end
    endgenerate

    assign head      = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
    assign head_dest = head[DATA_WIDTH-1:DATA_WIDTH-2];

    // Back-to-back pushes into a FIFO with one slot left would overflow it.
    assign dispatch = (state_reg != ST_EMPTY) && !full[head_dest] &&
                      !(push_reg[head_dest] && almost_full[head_dest]);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (accept) state_next = ST_ONE;
            ST_ONE: begin
                if (accept && !dispatch)      state_next = ST_TWO;
                else if (dispatch && !accept) state_next = ST_EMPTY;
            end
            ST_TWO:   if (dispatch) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_EMPTY;
            rd_ptr_reg     <= 1'b0;
            wr_ptr_reg     <= 1'b0;
            push_reg       <= 4'b0;
            data_out_reg   <= '0;
            push_id_reg    <= 2'd0;
            push_total_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (dispatch) begin
                rd_ptr_reg     <= ~rd_ptr_reg;
                push_reg       <= 4'b0001 << head_dest;
                data_out_reg   <= head;
                push_id_reg    <= head_dest;
                push_total_reg <= push_total_reg + 8'd1;
            end else begin
                push_reg <= 4'b0;
            end
        end
    end

    assign push       = push_reg;
    assign data_out   = data_out_reg;
    assign push_id    = push_id_reg;
    assign push_total = push_total_reg;

endmodule

// File: tb/tb_push_router.sv
// Directed bench for push_router: a queue scoreboard holds accepted words and
// checks each push for data, destination, id and running total.
module tb_push_router;

    logic       clk;
    logic       reset;
    logic [5:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic [3:0] full;
    logic [3:0] almost_full;
    logic [3:0] push;
    logic [5:0] data_out;
    logic [1:0] push_id;
    logic [7:0] push_total;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int exp_total = 0;
    logic [5:0] sb_q[$];

    push_router #(.DATA_WIDTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .full       (full),
        .almost_full(almost_full),
        .push       (push),
        .data_out   (data_out),
        .push_id    (push_id),
        .push_total (push_total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: log the accept seen before the edge, then score any push after it.
    task automatic tick();
        logic       acc;
        logic [5:0] w;
        acc = valid_in && ready_out;
        w   = data_in;
        @(posedge clk);
        if (reset) begin
            sb_q.delete();
            exp_total = 0;
        end else if (acc) begin
            sb_q.push_back(w);
        end
        #1;
        if (push !== 4'b0) begin
            exp_total++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_push", {28'b0, push}, 32'h0);
            end else begin
                w = sb_q.pop_front();
                check("sb_data", {26'b0, data_out}, {26'b0, w});
                check("sb_onehot", {28'b0, push}, {28'b0, 4'b0001 << w[5:4]});
                check("sb_id", {30'b0, push_id}, {30'b0, w[5:4]});
                check("sb_total", {24'b0, push_total}, exp_total & 255);
            end
        end
    endtask

    logic [3:0] pat [7];
    logic [3:0] exp_pat [7];
    logic       saw_wrap;

    initial begin
        reset = 1'b1; data_in = '0; valid_in = 1'b0; full = '0; almost_full = '0;
        tick(); tick();
        check("rst_ready", {31'b0, ready_out}, 0);
        check("rst_push", {28'b0, push}, 0);
        check("rst_data_out", {26'b0, data_out}, 0);
        check("rst_push_id", {30'b0, push_id}, 0);
        check("rst_total", {24'b0, push_total}, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, ready_out}, 1);

        // single word to destination 2, one-clock latency
        valid_in = 1'b1; data_in = 6'b10_0101;
        tick();
        valid_in = 1'b0;
        check("lat_no_push_yet", {28'b0, push}, 0);
        tick();
        check("lat_push", {28'b0, push}, 4'b0100);
        check("lat_id", {30'b0, push_id}, 2);
        check("lat_data", {26'b0, data_out}, 6'b10_0101);
        check("lat_total", {24'b0, push_total}, 1);
        tick();
        check("lat_push_clear", {28'b0, push}, 0);
        check("lat_id_hold", {30'b0, push_id}, 2);
        check("lat_data_hold", {26'b0, data_out}, 6'b10_0101);

        // head-of-line blocking on destination 1
        full = 4'b0010;
        valid_in = 1'b1; data_in = 6'b01_0001;
        tick();
        data_in = 6'b11_0010;
        tick();
        valid_in = 1'b0;
        check("hol_ready_low", {31'b0, ready_out}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hol_blocked", {28'b0, push}, 0);
        end
        full = 4'b0;
        tick();
        check("hol_first", {28'b0, push}, 4'b0010);
        tick();
        check("hol_second", {28'b0, push}, 4'b1000);
        tick();
        check("hol_done", {28'b0, push}, 0);

        // almost_full guard on destination 0
        almost_full = 4'b0001;
        exp_pat[0] = 4'b0000; exp_pat[1] = 4'b0001; exp_pat[2] = 4'b0000;
        exp_pat[3] = 4'b0001; exp_pat[4] = 4'b0000; exp_pat[5] = 4'b0001;
        exp_pat[6] = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            valid_in = (i < 3);
            data_in  = 6'(i + 1);
            tick();
            pat[i] = push;
        end
        valid_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("af_pattern_%0d", i), {28'b0, pat[i]}, {28'b0, exp_pat[i]});
        end
        almost_full = 4'b0;

        // streaming to rotating destinations, through the push_total wrap
        saw_wrap = 1'b0;
        for (int i = 0; i < 300; i++) begin
            valid_in = 1'b1;
            data_in  = {i[1:0], i[3:0]};
            check("stream_ready", {31'b0, ready_out}, 1);
            tick();
            if (i > 0) begin
                check("stream_push_each_cycle", {31'b0, push != 4'b0}, 1);
                if (push_total == 8'd0) saw_wrap = 1'b1;
            end
        end
        valid_in = 1'b0;
        tick();
        check("stream_wrap_seen", {31'b0, saw_wrap}, 1);
        check("stream_drained", {31'b0, ready_out}, 1);
        tick();
        check("stream_idle", {28'b0, push}, 0);

        // reset while holding two blocked words
        full = 4'hF;
        valid_in = 1'b1; data_in = 6'b00_1010;
        tick();
        data_in = 6'b01_1011;
        tick();
        valid_in = 1'b0;
        check("two_ready_low", {31'b0, ready_out}, 0);
        reset = 1'b1;
        #1;
        check("rst_mid_ready", {31'b0, ready_out}, 0);
        tick();
        check("rst_mid_push", {28'b0, push}, 0);
        check("rst_mid_total", {24'b0, push_total}, 0);
        reset = 1'b0;
        full = 4'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stale_no_push", {28'b0, push}, 0);
        end

        // flag activity with an empty buffer has no effect
        full = 4'b0101; almost_full = 4'b1010;
        tick();
        full = 4'b0; almost_full = 4'hF;
        tick();
        check("empty_flags_push", {28'b0, push}, 0);
        check("empty_flags_ready", {31'b0, ready_out}, 1);
        almost_full = 4'b0;

        check("sb_empty_at_end", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/push_router.md
PUSH_ROUTER -- requirements
Module: push_router

Interface
REQ-001 Parameter DATA_WIDTH, default 6, is the word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination id and the remaining bits are payload.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_in  input  DATA_WIDTH  word offered by the upstream source.
REQ-005 valid_in  input  1  data_in valid this cycle.
REQ-006 ready_out  output  1  router accepts a word this cycle; transfer occurs when valid_in && ready_out.
REQ-007 full  input  4  per-destination FIFO full flags; bit d belongs to FIFO d.
REQ-008 almost_full  input  4  per-destination almost-full flags (one slot left).
REQ-009 push  output  4  one-hot push strobe to destination FIFOs; at most one bit high.
REQ-010 data_out  output  DATA_WIDTH  word written to the FIFO selected by push, valid while push != 0.
REQ-011 push_id  output  2  binary index of the asserted push bit; holds its last value when push == 0.
REQ-012 push_total  output  8  count of words pushed since reset, wraps 255 -> 0.

Function
REQ-013 The router SHALL hold accepted words in a 2-entry in-order buffer, with occupancy state machine EMPTY, ONE or TWO.
REQ-014 ready_out SHALL be 1 exactly when the state is EMPTY or ONE and reset is low; it SHALL NOT depend on full, almost_full or dispatch in the same cycle.
REQ-015 Accept: valid_in && ready_out SHALL write data_in to the buffer tail at the clock edge.
REQ-016 Dispatch: the head word with destination d SHALL be dispatched when all of the following hold:
- the buffer is non-empty;
- full[d] == 0;
- the guard of REQ-017 does not hold.
Dispatch registers push = (1 << d), data_out = head and push_id = d for the next cycle, and removes the head.
REQ-017 Guard: if push[d] was asserted in the previous cycle and almost_full[d] == 1, no push to d SHALL occur this cycle.
REQ-018 When no dispatch occurs, push SHALL be 0 in the next cycle, and data_out and push_id SHALL hold.
REQ-019 Latency: a word accepted at edge N into an EMPTY buffer, with its destination free, SHALL produce push at cycle N+1 (one clock).
REQ-020 Blocking is head-of-line: a blocked head SHALL block the second entry even if that entry's destination is free; order SHALL be preserved.
REQ-021 Simultaneous accept and dispatch SHALL leave the state unchanged.
REQ-022 Transitions:
- EMPTY->ONE on accept.
- ONE->TWO on accept without dispatch.
- ONE->EMPTY on dispatch without accept.
- TWO->ONE on dispatch.
- Otherwise the state holds.
REQ-023 push_total SHALL increment by 1 on every cycle in which push != 0, wrapping modulo 256.
REQ-024 Changes on full or almost_full while the buffer is EMPTY SHALL have no effect.

Reset
REQ-025 While reset is high, at each edge: state = EMPTY, push = 0, data_out = 0, push_id = 0, push_total = 0, previous-push history cleared; ready_out SHALL read 0 while reset is high.
REQ-026 Reset asserted mid-operation SHALL discard buffered words without pushing them.
REQ-027 The first accept SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-028 After reset, send data_in=6'b10_0101 with full=0 -> next cycle push=4'b0100, push_id=2, data_out=6'b10_0101, push_total=1.
REQ-029 With full[1]=1, send 6'b01_0001 then 6'b11_0010 -> ready_out=0 after the second word, push stays 0 (head-of-line); release full[1] -> push=0010 then 1000 on consecutive cycles.
REQ-030 With almost_full[0]=1, stream three words to destination 0 back-to-back -> the pattern is push=0001, push=0000, push=0001, with no two consecutive pushes to destination 0.
REQ-031 Continuous valid_in to rotating destinations 0..3 with all full=0 -> one push per cycle, ready_out stays 1, order preserved, and push_total wraps 255->0 after 256 pushes.
REQ-032 Buffer in state TWO with full=4'hF, then assert reset for one cycle -> push=0, ready_out=0 during reset; after reset, full=0 yields no push of the stale words.
